// File: rtl/xmax_pkg.sv
// Shared types and helpers for the N-input exclusive-max temporal block.
package xmax_pkg;

   typedef enum logic {XMAX_RISING, XMAX_FALLING} xmax_edge_e;

   localparam int unsigned XMAX_MAX_N = 32;

   typedef struct packed {
      logic [1:0] cnt;
      logic [4:0] idx;
   } xmax_pop_t;

   // Count saturates at 2; idx is the lowest set bit (descending scan lets it win).
   function automatic xmax_pop_t popcount_onehot_idx(input logic [XMAX_MAX_N-1:0] vec);
      xmax_pop_t r;
      r.cnt = 2'd0;
      r.idx = 5'd0;
      for (int i = XMAX_MAX_N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            r.idx = 5'(i);
            if (r.cnt != 2'd2) r.cnt = r.cnt + 2'd1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tc_edge_detect.sv
// Per-channel edge detector; the previous-value register resets to the idle level of the polarity.
module tc_edge_detect
   import xmax_pkg::*;
#(
   parameter xmax_edge_e EDGE_MODE = XMAX_RISING
) (
   input  logic aclk,
   input  logic grst,
   input  logic spk,
   output logic strobe
);

   localparam logic IdleLevel = (EDGE_MODE == XMAX_FALLING);

   logic prev_q;

   always_ff @(posedge aclk or posedge grst) begin
      if (grst) prev_q <= IdleLevel;
      else      prev_q <= spk;
   end

   assign strobe = (EDGE_MODE == XMAX_FALLING) ? (prev_q & ~spk) : (~prev_q & spk);

endmodule

// File: rtl/xmax_n.sv
// N-input exclusive-max: fires once per gamma cycle when the last input arrives alone.
module xmax_n
   import xmax_pkg::*;
#(
   parameter int unsigned N_IN              = 4,
   parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
   parameter int unsigned PULSE_WIDTH       = 8,
   parameter xmax_edge_e  EDGE_MODE         = XMAX_RISING
) (
   input  logic                                 aclk,
   input  logic                                 grst,
   input  logic                                 rst,
   input  logic [N_IN-1:0]                      in_spk,
   output logic                                 q,
   output logic [$clog2(N_IN)-1:0]              win_idx,
   output logic [$clog2(GAMMA_CYCLE_WIDTH)-1:0] win_time,
   output logic                                 tie,
   output logic                                 win_open
);

   localparam int unsigned IW = $clog2(N_IN);
   localparam int unsigned TW = $clog2(GAMMA_CYCLE_WIDTH);
   localparam int unsigned PW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
   localparam logic [TW-1:0]   TLast  = TW'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [N_IN-1:0] AllArr = '1;

   logic [N_IN-1:0] edge_s, evt;
   logic [N_IN-1:0] arrived_q, arrived_d;
   logic [TW-1:0]   tcount_q, tcount_d;
   logic [PW-1:0]   pcnt_q, pcnt_d;
   logic            q_d, tie_d, open_d;
   logic [IW-1:0]   idx_d;
   logic [TW-1:0]   time_d;
   xmax_pop_t       pop;
   logic            unused_pop_idx;

   for (genvar g = 0; g < N_IN; g++) begin : g_edge
      tc_edge_detect #(
         .EDGE_MODE(EDGE_MODE)
      ) u_edge (
         .aclk  (aclk),
         .grst  (grst),
         .spk   (in_spk[g]),
         .strobe(edge_s[g])
      );
   end

   // Only first edges of still-missing channels count, and only inside an open window.
   assign evt = edge_s & ~arrived_q & {N_IN{win_open & ~rst}};
   assign pop = popcount_onehot_idx(XMAX_MAX_N'(evt));
   assign unused_pop_idx = ^pop.idx;

   always_comb begin
      arrived_d = arrived_q;
      tcount_d  = tcount_q;
      pcnt_d    = pcnt_q;
      q_d       = q;
      tie_d     = 1'b0;
      open_d    = win_open;
      idx_d     = win_idx;
      time_d    = win_time;

      if (q) begin
         if (pcnt_q == '0) q_d = 1'b0;
         else              pcnt_d = pcnt_q - 1'b1;
      end

      if (rst) begin
         arrived_d = '0;
         tcount_d  = '0;
         open_d    = 1'b1;
         q_d       = 1'b0;
         pcnt_d    = '0;
      end else if (win_open) begin
         arrived_d = arrived_q | evt;
         if (tcount_q != TLast) tcount_d = tcount_q + 1'b1;
         if ((arrived_q | evt) == AllArr) begin
            open_d = 1'b0;
            if (pop.cnt == 2'd1) begin
               q_d    = 1'b1;
               pcnt_d = PW'(PULSE_WIDTH - 1);
               idx_d  = pop.idx[IW-1:0];
               time_d = tcount_q;
            end else if (pop.cnt == 2'd2) begin
               tie_d = 1'b1;
            end
         end else if (tcount_q == TLast) begin
            // Window expired with the set incomplete: null result.
            open_d = 1'b0;
         end
      end
   end

   always_ff @(posedge aclk or posedge grst) begin
      if (grst) begin
         arrived_q <= '0;
         tcount_q  <= '0;
         pcnt_q    <= '0;
         q         <= 1'b0;
         tie       <= 1'b0;
         win_open  <= 1'b0;
         win_idx   <= '0;
         win_time  <= '0;
      end else begin
         arrived_q <= arrived_d;
         tcount_q  <= tcount_d;
         pcnt_q    <= pcnt_d;
         q         <= q_d;
         tie       <= tie_d;
         win_open  <= open_d;
         win_idx   <= idx_d;
         win_time  <= time_d;
      end
   end

endmodule

// File: tb/tb_xmax_n.sv
// Bench for xmax_n: rising and falling instances share stimulus (falling sees inverted lines).
module tb_xmax_n;
   import xmax_pkg::*;

   localparam int N  = 4;
   localparam int G  = 16;
   localparam int PW = 8;

   logic         aclk = 1'b0;
   logic         grst = 1'b1;
   logic         rst  = 1'b0;
   logic [N-1:0] spk  = '0;
   logic [N-1:0] spk_n;
   logic         q_r, tie_r, open_r, q_f, tie_f, open_f;
   logic [1:0]   idx_r, idx_f;
   logic [3:0]   time_r, time_f;

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  chk_en   = 1'b0;

   assign spk_n = ~spk;

   always #5 aclk = ~aclk;

   xmax_n #(.N_IN(N), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .EDGE_MODE(XMAX_RISING)) dut_r (
      .aclk(aclk), .grst(grst), .rst(rst), .in_spk(spk), .q(q_r), .win_idx(idx_r),
      .win_time(time_r), .tie(tie_r), .win_open(open_r)
   );

   xmax_n #(.N_IN(N), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW), .EDGE_MODE(XMAX_FALLING)) dut_f (
      .aclk(aclk), .grst(grst), .rst(rst), .in_spk(spk_n), .q(q_f), .win_idx(idx_f),
      .win_time(time_f), .tie(tie_f), .win_open(open_f)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: record first-arrival time per channel within the window, decide on
   // completion by comparing the latest arrival time against the others.
   int           win_t    = 0;
   bit           m_open   = 1'b0;
   int           first_t[N] = '{default: -1};
   int           q_left   = 0;
   int           m_idx    = 0;
   int           m_time   = 0;
   bit           m_tie    = 1'b0;
   logic [N-1:0] prev_spk = '0;

   always @(posedge aclk or posedge grst) begin : model
      logic [N-1:0] edg;
      int           t, latest, nlat, widx;
      bit           all_in;
      if (grst) begin
         win_t = 0; m_open = 1'b0; q_left = 0; m_idx = 0; m_time = 0; m_tie = 1'b0;
         prev_spk = '0;
         for (int i = 0; i < N; i++) first_t[i] = -1;
      end else begin
         edg = spk & ~prev_spk;
         prev_spk = spk;
         m_tie = 1'b0;
         if (q_left > 0) q_left--;
         if (rst) begin
            m_open = 1'b1; win_t = 0; q_left = 0;
            for (int i = 0; i < N; i++) first_t[i] = -1;
         end else if (m_open) begin
            t = (win_t < G - 1) ? win_t : G - 1;
            for (int i = 0; i < N; i++) if (edg[i] && first_t[i] < 0) first_t[i] = t;
            all_in = 1'b1; latest = -1;
            for (int i = 0; i < N; i++) begin
               if (first_t[i] < 0) all_in = 1'b0;
               else if (first_t[i] > latest) latest = first_t[i];
            end
            if (all_in) begin
               nlat = 0; widx = 0;
               for (int i = 0; i < N; i++) if (first_t[i] == latest) begin nlat++; widx = i; end
               m_open = 1'b0;
               if (nlat == 1) begin q_left = PW; m_idx = widx; m_time = latest; end
               else m_tie = 1'b1;
            end else if (win_t >= G - 1) begin
               m_open = 1'b0;
            end
            win_t++;
         end
      end
   end

   always @(negedge aclk) begin
      if (chk_en) begin
         check("q_rise",     q_r,    (q_left > 0) ? 1 : 0);
         check("tie_rise",   tie_r,  m_tie);
         check("open_rise",  open_r, m_open);
         check("idx_rise",   idx_r,  m_idx);
         check("time_rise",  time_r, m_time);
         check("q_fall",     q_f,    (q_left > 0) ? 1 : 0);
         check("tie_fall",   tie_f,  m_tie);
         check("open_fall",  open_f, m_open);
         check("idx_fall",   idx_f,  m_idx);
         check("time_fall",  time_f, m_time);
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // rst is high for one cycle; on return the bench is in window time 0.
   task automatic open_window();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   // Raise channel i in window cycle ti, for cycles 0..len-1; returns in cycle len.
   task automatic drive_times(input int t0, input int t1, input int t2, input int t3,
                              input int len);
      for (int c = 0; c < len; c++) begin
         if (c == t0) spk[0] = 1'b1;
         if (c == t1) spk[1] = 1'b1;
         if (c == t2) spk[2] = 1'b1;
         if (c == t3) spk[3] = 1'b1;
         tick();
      end
   endtask

   initial begin
      repeat (2) @(posedge aclk);
      #1;
      chk_en = 1'b1;
      tick();
      grst = 1'b0;
      tick();
      check("rst_q", q_r, 0);
      check("rst_open", open_r, 0);
      check("rst_idx", idx_r, 0);
      check("rst_q_fall", q_f, 0);

      // Single winner.
      open_window();
      drive_times(2, 3, 5, 9, 10);
      check("t1_q", q_r, 1);
      check("t1_idx", idx_r, 3);
      check("t1_time", time_r, 9);
      check("t1_tie", tie_r, 0);
      check("t1_q_fall", q_f, 1);
      repeat (7) tick();
      check("t1_q_last", q_r, 1);
      tick();
      check("t1_q_drop", q_r, 0);
      check("t1_idx_hold", idx_r, 3);

      // Tied last arrival.
      spk = '0;
      open_window();
      drive_times(2, 3, 9, 9, 10);
      check("t2_tie", tie_r, 1);
      check("t2_q", q_r, 0);
      check("t2_open", open_r, 0);
      tick();
      check("t2_tie_drop", tie_r, 0);

      // Missing channel: window expires with null result.
      spk = '0;
      open_window();
      drive_times(1, 2, 3, 99, 15);
      check("t3_open15", open_r, 1);
      tick();
      check("t3_open16", open_r, 0);
      check("t3_q", q_r, 0);
      check("t3_time_hold", time_r, 9);

      // rst mid-pulse, then a new window won at the last legal cycle.
      spk = '0;
      open_window();
      drive_times(2, 3, 5, 9, 10);
      repeat (2) tick();
      spk = '0;
      open_window();
      check("t4_q_cut", q_r, 0);
      drive_times(0, 4, 7, 15, 16);
      check("t4_q", q_r, 1);
      check("t4_time", time_r, 15);
      check("t4_idx", idx_r, 3);

      // grst mid-pulse clears outputs asynchronously.
      tick();
      spk = '0;
      #3 grst = 1'b1;
      #1;
      check("grst_q", q_r, 0);
      check("grst_time", time_r, 0);
      check("grst_q_fall", q_f, 0);
      tick();
      grst = 1'b0;
      tick();

      // Edge during rst is ignored; repeated toggles count once.
      spk = 4'b0001;
      open_window();
      for (int c = 0; c < 12; c++) begin
         case (c)
            1:  spk = 4'b0010;
            2:  spk[1] = 1'b0;
            3:  spk = 4'b0110;
            4:  spk[1] = 1'b0;
            5:  spk[1] = 1'b1;
            6:  spk[3] = 1'b1;
            11: spk[0] = 1'b1;
            default: ;
         endcase
         tick();
      end
      check("t5_q", q_r, 1);
      check("t5_idx", idx_r, 0);
      check("t5_time", time_r, 11);

      // Random phase against the model.
      for (int c = 0; c < 2500; c++) begin
         for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) spk[i] = ~spk[i];
         rst = ($urandom_range(29) == 0);
         if (c == 1200) grst = 1'b1;
         if (c == 1203) grst = 1'b0;
         tick();
      end
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
